// File: rtl/fade_sequencer.sv
// N-channel colour-wheel cross-fade generator: steps one channel's duty per step tick over 2*N phases.
// Optional per-phase dwell (HOLD state) is built only when FADE_SEQ_HOLD_EN is defined.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_RUN  | each tick moves the phase target channel by DUTY_STEP
//   ST_HOLD | duties frozen for HOLD_STEPS ticks after a phase completes
module fade_sequencer #(
    parameter int NUM_CH          = 3,
    parameter int PWM_INTERVAL    = 1200,
    parameter int STEP_INTERVAL   = 12000,
    parameter int STEPS_PER_PHASE = 200,
    parameter int HOLD_STEPS      = 0,
    localparam int DUTY_W         = $clog2(PWM_INTERVAL),
    localparam int PH_W           = $clog2(2 * NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     restart,
    output logic [NUM_CH*DUTY_W-1:0] duty_flat,
    output logic [PH_W-1:0]          phase,
    output logic                     step_tick,
    output logic                     phase_done
);
    localparam int MAX_DUTY  = PWM_INTERVAL - 1;
    localparam int DUTY_STEP = PWM_INTERVAL / STEPS_PER_PHASE;
    localparam int PS_W      = (STEP_INTERVAL > 1) ? $clog2(STEP_INTERVAL) : 1;
    localparam int SC_W      = (STEPS_PER_PHASE > 1) ? $clog2(STEPS_PER_PHASE) : 1;

    localparam logic [PS_W-1:0]   PS_LAST  = PS_W'(STEP_INTERVAL - 1);
    localparam logic [SC_W-1:0]   SC_LAST  = SC_W'(STEPS_PER_PHASE - 1);
    localparam logic [PH_W-1:0]   PH_LAST  = PH_W'(2 * NUM_CH - 1);
    localparam logic [DUTY_W-1:0] MAX_D    = DUTY_W'(MAX_DUTY);
    localparam logic [DUTY_W:0]   MAX_EXT  = (DUTY_W + 1)'(MAX_DUTY);
    localparam logic [DUTY_W:0]   STEP_EXT = (DUTY_W + 1)'(DUTY_STEP);

    if (NUM_CH < 2 || STEP_INTERVAL < 1 || STEPS_PER_PHASE < 1 || HOLD_STEPS < 0) begin : g_bad_param
        $error("fade_sequencer: illegal parameter combination");
    end

    typedef enum logic {ST_RUN, ST_HOLD} state_t;

    state_t            state, state_nxt;
    logic [PS_W-1:0]   presc, presc_nxt;
    logic [SC_W-1:0]   step_cnt, step_cnt_nxt;
    logic [PH_W-1:0]   phase_nxt;
    logic [DUTY_W-1:0] duty [NUM_CH];
    logic [DUTY_W-1:0] duty_nxt [NUM_CH];
    logic              step_tick_nxt, phase_done_nxt;
    logic              tick, is_inc;
    logic [DUTY_W-1:0] cur_duty, new_duty;
    logic [DUTY_W:0]   sum_ext;
    int                tgt;

`ifdef FADE_SEQ_HOLD_EN
    localparam int HC_W = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
    localparam logic [HC_W-1:0] HC_LAST = HC_W'((HOLD_STEPS > 0) ? HOLD_STEPS - 1 : 0);
    logic [HC_W-1:0] hold_cnt, hold_cnt_nxt;
`endif

    for (genvar g = 0; g < NUM_CH; g++) begin : g_flat
        assign duty_flat[g*DUTY_W +: DUTY_W] = duty[g];
    end

    // Even phases raise channel (k+1) mod N, odd phases lower channel k; sums are one bit wider so they saturate.
    always_comb begin
        is_inc   = ~phase[0];
        tgt      = is_inc ? ((int'(phase >> 1) + 1) % NUM_CH) : int'(phase >> 1);
        cur_duty = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (i == tgt) cur_duty = duty[i];
        end
        if (is_inc) begin
            sum_ext  = {1'b0, cur_duty} + STEP_EXT;
            new_duty = (sum_ext > MAX_EXT) ? MAX_D : sum_ext[DUTY_W-1:0];
        end else begin
            sum_ext  = {1'b0, cur_duty} - STEP_EXT;
            new_duty = ({1'b0, cur_duty} < STEP_EXT) ? '0 : sum_ext[DUTY_W-1:0];
        end
    end

    always_comb begin
        tick           = enable && (presc == PS_LAST);
        presc_nxt      = presc;
        step_cnt_nxt   = step_cnt;
        phase_nxt      = phase;
        state_nxt      = state;
        step_tick_nxt  = tick;
        phase_done_nxt = 1'b0;
        for (int i = 0; i < NUM_CH; i++) duty_nxt[i] = duty[i];
`ifdef FADE_SEQ_HOLD_EN
        hold_cnt_nxt   = hold_cnt;
`endif
        if (enable) presc_nxt = tick ? '0 : presc + 1'b1;
        if (tick) begin
            unique case (state)
                ST_RUN: begin
                    if (step_cnt == SC_LAST) begin
                        for (int i = 0; i < NUM_CH; i++) begin
                            if (i == tgt) duty_nxt[i] = is_inc ? MAX_D : '0;
                        end
                        step_cnt_nxt   = '0;
                        phase_nxt      = (phase == PH_LAST) ? '0 : phase + 1'b1;
                        phase_done_nxt = 1'b1;
`ifdef FADE_SEQ_HOLD_EN
                        if (HOLD_STEPS > 0) state_nxt = ST_HOLD;
`endif
                    end else begin
                        for (int i = 0; i < NUM_CH; i++) begin
                            if (i == tgt) duty_nxt[i] = new_duty;
                        end
                        step_cnt_nxt = step_cnt + 1'b1;
                    end
                end
                ST_HOLD: begin
`ifdef FADE_SEQ_HOLD_EN
                    if (hold_cnt == HC_LAST) begin
                        hold_cnt_nxt = '0;
                        state_nxt    = ST_RUN;
                    end else begin
                        hold_cnt_nxt = hold_cnt + 1'b1;
                    end
`else
                    state_nxt = ST_RUN;
`endif
                end
                default: state_nxt = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_RUN;
            presc      <= '0;
            step_cnt   <= '0;
            phase      <= '0;
            step_tick  <= 1'b0;
            phase_done <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) duty[i] <= (i == 0) ? MAX_D : '0;
`ifdef FADE_SEQ_HOLD_EN
            hold_cnt   <= '0;
`endif
        end else if (restart) begin
            state      <= ST_RUN;
            presc      <= '0;
            step_cnt   <= '0;
            phase      <= '0;
            step_tick  <= 1'b0;
            phase_done <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) duty[i] <= (i == 0) ? MAX_D : '0;
`ifdef FADE_SEQ_HOLD_EN
            hold_cnt   <= '0;
`endif
        end else begin
            state      <= state_nxt;
            presc      <= presc_nxt;
            step_cnt   <= step_cnt_nxt;
            phase      <= phase_nxt;
            step_tick  <= step_tick_nxt;
            phase_done <= phase_done_nxt;
            for (int i = 0; i < NUM_CH; i++) duty[i] <= duty_nxt[i];
`ifdef FADE_SEQ_HOLD_EN
            hold_cnt   <= hold_cnt_nxt;
`endif
        end
    end
endmodule

// File: tb/tb_fade_sequencer.sv
// Directed bench for fade_sequencer with NUM_CH=3, PWM_INTERVAL=12, STEP_INTERVAL=4, STEPS_PER_PHASE=4.
// Expectations follow FADE_SEQ_HOLD_EN the same way the DUT build does (HOLD_STEPS=2 on the instance).
module tb_fade_sequencer;
    localparam int DW = 4;
    localparam int SI = 4;
`ifdef FADE_SEQ_HOLD_EN
    localparam int HOLD = 2;
`else
    localparam int HOLD = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b1;
    logic          restart = 1'b0;
    logic [3*DW-1:0] duty_flat;
    logic [2:0]    phase;
    logic          step_tick;
    logic          phase_done;

    fade_sequencer #(
        .NUM_CH(3), .PWM_INTERVAL(12), .STEP_INTERVAL(SI), .STEPS_PER_PHASE(4), .HOLD_STEPS(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .restart(restart),
        .duty_flat(duty_flat), .phase(phase), .step_tick(step_tick), .phase_done(phase_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pause;
        int d0, d1, d2;
        int ph;
        int pd;
    } vec_t;

    vec_t vecs [24];
    int   n_checks = 0;
    int   n_pass = 0;
    int   n_st = 0;
    int   n_pd = 0;

    function automatic int ch(input int i);
        logic [3*DW-1:0] f;
        f = duty_flat;
        return int'(f[i*DW +: DW]);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic cyc();
        @(negedge clk);
        if (step_tick) n_st++;
        if (phase_done) n_pd++;
    endtask

    task automatic wait_tick(output int gap);
        gap = 0;
        for (int i = 0; i < 50; i++) begin
            cyc();
            gap++;
            if (step_tick) return;
        end
        check("tick_timeout", 0, 1);
    endtask

    initial begin
        int gap, s0, s1, s2, sph, bad;
        vecs = '{
            '{0, 11, 3, 0, 0, 0}, '{0, 11, 6, 0, 0, 0}, '{0, 11, 9, 0, 0, 0}, '{0, 11, 11, 0, 1, 1},
            '{0, 8, 11, 0, 1, 0}, '{0, 5, 11, 0, 1, 0}, '{0, 2, 11, 0, 1, 0}, '{0, 0, 11, 0, 2, 1},
            '{0, 0, 11, 3, 2, 0}, '{10, 0, 11, 6, 2, 0}, '{0, 0, 11, 9, 2, 0}, '{0, 0, 11, 11, 3, 1},
            '{0, 0, 8, 11, 3, 0}, '{0, 0, 5, 11, 3, 0}, '{0, 0, 2, 11, 3, 0}, '{0, 0, 0, 11, 4, 1},
            '{0, 3, 0, 11, 4, 0}, '{0, 6, 0, 11, 4, 0}, '{0, 9, 0, 11, 4, 0}, '{0, 11, 0, 11, 5, 1},
            '{0, 11, 0, 8, 5, 0}, '{0, 11, 0, 5, 5, 0}, '{0, 11, 0, 2, 5, 0}, '{0, 11, 0, 0, 0, 1}
        };

        // reset state
        cyc();
        check("rst_d0", ch(0), 11);
        check("rst_d1", ch(1), 0);
        check("rst_d2", ch(2), 0);
        check("rst_phase", int'(phase), 0);
        check("rst_tick", int'(step_tick), 0);
        check("rst_pd", int'(phase_done), 0);
        rst_n = 1'b1;
        n_st = 0;
        n_pd = 0;

        // full wheel, with a pause before tick 10 and hold dwell when built in
        for (int v = 0; v < 24; v++) begin
            if (vecs[v].pause > 0) begin
                s0 = ch(0); s1 = ch(1); s2 = ch(2); bad = 0;
                enable = 1'b0;
                for (int k = 0; k < vecs[v].pause; k++) begin
                    cyc();
                    if (step_tick || ch(0) != s0 || ch(1) != s1 || ch(2) != s2) bad++;
                end
                check("pause_frozen", bad, 0);
                enable = 1'b1;
            end
            wait_tick(gap);
            check($sformatf("v%0d_gap", v + 1), gap, SI);
            check($sformatf("v%0d_d0", v + 1), ch(0), vecs[v].d0);
            check($sformatf("v%0d_d1", v + 1), ch(1), vecs[v].d1);
            check($sformatf("v%0d_d2", v + 1), ch(2), vecs[v].d2);
            check($sformatf("v%0d_phase", v + 1), int'(phase), vecs[v].ph);
            check($sformatf("v%0d_pd", v + 1), int'(phase_done), vecs[v].pd);
            if (vecs[v].pd != 0) begin
                for (int h = 0; h < HOLD; h++) begin
                    wait_tick(gap);
                    check("hold_gap", gap, SI);
                    check("hold_duty", (ch(0) == vecs[v].d0 && ch(1) == vecs[v].d1 && ch(2) == vecs[v].d2) ? 1 : 0, 1);
                    check("hold_phase", int'(phase), vecs[v].ph);
                    check("hold_pd", int'(phase_done), 0);
                end
            end
        end
        check("wheel_ticks", n_st, 24 + 6 * HOLD);
        check("wheel_pd", n_pd, 6);

        // enable dropped in the tick cycle: tick deferred to first enabled cycle
        cyc(); cyc(); cyc();
        enable = 1'b0;
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            cyc();
            if (step_tick) bad++;
        end
        check("en_drop_no_tick", bad, 0);
        enable = 1'b1;
        cyc();
        check("en_resume_tick", int'(step_tick), 1);
        check("en_resume_d1", ch(1), 3);

        // restart coincident with a tick discards that tick
        cyc(); cyc(); cyc();
        restart = 1'b1;
        cyc();
        restart = 1'b0;
        check("rs_d0", ch(0), 11);
        check("rs_d1", ch(1), 0);
        check("rs_phase", int'(phase), 0);
        check("rs_tick", int'(step_tick), 0);
        wait_tick(gap);
        check("rs_gap", gap, SI);
        check("rs_first_d1", ch(1), 3);

        // asynchronous reset at tick 6
        for (int t = 2; t <= 6; t++) wait_tick(gap);
        check("t6_d0", ch(0), (HOLD > 0) ? 11 : 5);
        check("t6_phase", int'(phase), 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_d0", ch(0), 11);
        check("arst_d1", ch(1), 0);
        check("arst_phase", int'(phase), 0);
        check("arst_tick", int'(step_tick), 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_tick(gap);
        check("arst_gap", gap, SI);
        check("arst_first_d1", ch(1), 3);
        sph = int'(phase);
        check("arst_first_phase", sph, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
